// File: rtl/z380_dram_refresh_arb.sv
// z380_dram_refresh_arb
//   Refresh consumer for the Z380 platform uncore. Counts refresh_tick pulses
//   as owed refreshes. Each owed refresh is arbitrated against CPU memory
//   traffic and then issued to the DRAM sequencer over ref_req/ref_ack.
//   A refresh runs opportunistically while the CPU is idle. It is forced once
//   the backlog reaches URGENT_THRESH.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   refresh_tick      one-cycle pulse: one more refresh owed
//   ovf_clr           clears the sticky refresh_overflow flag
//   cpu_req_valid/ready   CPU request side of the pass-through
//   mem_req_valid/ready   DRAM sequencer side of the pass-through
//   mem_busy          a CPU access is still in flight at the sequencer
//   ref_req/ref_ack   refresh command handshake (fire = ref_req && ref_ack)
//   pending_cnt       owed refreshes
//   refresh_busy      arbiter is not in IDLE
//   refresh_overflow  sticky: a tick was dropped because the count was saturated
module z380_dram_refresh_arb #(
  parameter int PEND_W         = 4,
  parameter int MAX_PENDING    = 8,
  parameter int URGENT_THRESH  = 4,
  parameter int RECOVER_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              refresh_tick,
  input  logic              ovf_clr,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  input  logic              mem_busy,
  output logic              ref_req,
  input  logic              ref_ack,
  output logic [PEND_W-1:0] pending_cnt,
  output logic              refresh_busy,
  output logic              refresh_overflow
);

  localparam int REC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [REC_W-1:0]  REC_INIT = (RECOVER_CYCLES > 0) ? REC_W'(RECOVER_CYCLES - 1) : '0;
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0] PEND_URG = PEND_W'(URGENT_THRESH);
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAIN   = 2'd1,
    S_REQ     = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic [REC_W-1:0]  rec_cnt_q, rec_cnt_d;
  logic              ovf_q, ovf_d;
  logic              fire;
  logic              ovf_set;

  // A refresh is consumed only while actually in REQ; stray acks are ignored.
  assign fire = (state_q == S_REQ) && ref_ack;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      rec_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rec_cnt_q <= rec_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Pending counter and overflow flag
  always_comb begin
    pending_d = pending_q;
    ovf_set   = 1'b0;
    if (refresh_tick && !fire) begin
      if (pending_q == PEND_MAX) begin
        ovf_set = 1'b1;
      end else begin
        pending_d = pending_q + PEND_ONE;
      end
    end else if (fire && !refresh_tick) begin
      pending_d = pending_q - PEND_ONE;
    end
    // A new overflow in the same cycle as ovf_clr must not be lost.
    ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    rec_cnt_d = rec_cnt_q;
    case (state_q)
      S_IDLE: begin
        if ((pending_q != '0) && ((pending_q >= PEND_URG) || !cpu_req_valid)) begin
          state_d = S_DRAIN;
        end
      end
      // Always spends at least one cycle here so that mem_busy from an access
      // accepted on the IDLE exit cycle is observed before issuing.
      S_DRAIN: begin
        if (!mem_busy) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (fire) begin
          if (RECOVER_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_RECOVER;
            rec_cnt_d = REC_INIT;
          end
        end
      end
      S_RECOVER: begin
        if (rec_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          rec_cnt_d = rec_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend on registered state only; IDLE passes the CPU through.
  always_comb begin
    ref_req          = (state_q == S_REQ);
    refresh_busy     = (state_q != S_IDLE);
    mem_req_valid    = (state_q == S_IDLE) ? cpu_req_valid : 1'b0;
    cpu_req_ready    = (state_q == S_IDLE) ? mem_req_ready : 1'b0;
    pending_cnt      = pending_q;
    refresh_overflow = ovf_q;
  end

endmodule

// File: tb/tb_z380_dram_refresh_arb.sv
module tb_z380_dram_refresh_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       refresh_tick = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       cpu_req_valid = 1'b0;
  logic       cpu_req_ready;
  logic       mem_req_valid;
  logic       mem_req_ready = 1'b0;
  logic       mem_busy = 1'b0;
  logic       ref_req;
  logic       ref_ack = 1'b0;
  logic [3:0] pending_cnt;
  logic       refresh_busy;
  logic       refresh_overflow;

  int n_cmp = 0;
  int n_err = 0;

  z380_dram_refresh_arb #(
    .PEND_W(4), .MAX_PENDING(8), .URGENT_THRESH(4), .RECOVER_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .refresh_tick(refresh_tick), .ovf_clr(ovf_clr),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_busy(mem_busy), .ref_req(ref_req), .ref_ack(ref_ack),
    .pending_cnt(pending_cnt), .refresh_busy(refresh_busy),
    .refresh_overflow(refresh_overflow)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs changed after this take effect at the next edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with all inputs low
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_pending", 32'(pending_cnt), 0);
    chk("rst_ref_req", 32'(ref_req), 0);
    chk("rst_busy", 32'(refresh_busy), 0);
    chk("rst_ovf", 32'(refresh_overflow), 0);
    chk("rst_cpu_ready0", 32'(cpu_req_ready), 0);
    mem_req_ready = 1'b1; cpu_req_valid = 1'b1; #1;
    chk("rst_cpu_ready1", 32'(cpu_req_ready), 1);
    chk("rst_mem_valid1", 32'(mem_req_valid), 1);
    cpu_req_valid = 1'b0; #1;
    chk("rst_mem_valid0", 32'(mem_req_valid), 0);

    // Idle CPU, single tick, ack tied high
    ref_ack = 1'b1;
    refresh_tick = 1'b1; cyc(); refresh_tick = 1'b0;
    chk("t2_pend1", 32'(pending_cnt), 1);
    chk("t2_idle", 32'(refresh_busy), 0);
    cyc();
    chk("t2_drain_busy", 32'(refresh_busy), 1);
    chk("t2_drain_noreq", 32'(ref_req), 0);
    chk("t2_drain_gate", 32'(cpu_req_ready), 0);
    cyc();
    chk("t2_req", 32'(ref_req), 1);
    cyc();
    chk("t2_rec1_req", 32'(ref_req), 0);
    chk("t2_rec1_pend", 32'(pending_cnt), 0);
    chk("t2_rec1_busy", 32'(refresh_busy), 1);
    cyc();
    chk("t2_rec2_busy", 32'(refresh_busy), 1);
    cyc();
    chk("t2_rec3_busy", 32'(refresh_busy), 1);
    cyc();
    chk("t2_back_idle", 32'(refresh_busy), 0);
    chk("t2_ready_back", 32'(cpu_req_ready), 1);
    ref_ack = 1'b0;

    // CPU busy: three ticks stay owed, fourth forces the refresh
    cpu_req_valid = 1'b1;
    refresh_tick = 1'b1; cyc(); cyc(); cyc(); refresh_tick = 1'b0;
    cyc();
    chk("t3_pend3", 32'(pending_cnt), 3);
    chk("t3_noreq", 32'(ref_req), 0);
    chk("t3_idle", 32'(refresh_busy), 0);
    chk("t3_pass", 32'(mem_req_valid), 1);
    refresh_tick = 1'b1; cyc(); refresh_tick = 1'b0;
    chk("t3_pend4", 32'(pending_cnt), 4);
    chk("t3_exit_pass", 32'(cpu_req_ready), 1);
    cyc();
    chk("t3_drain", 32'(refresh_busy), 1);
    chk("t3_drain_ready", 32'(cpu_req_ready), 0);
    chk("t3_drain_valid", 32'(mem_req_valid), 0);
    cyc();
    chk("t3_req", 32'(ref_req), 1);
    cyc();
    chk("t3_req_held", 32'(ref_req), 1);
    ref_ack = 1'b1; cyc(); ref_ack = 1'b0;
    chk("t3_fire_pend", 32'(pending_cnt), 3);
    chk("t3_rec_ready", 32'(cpu_req_ready), 0);
    cyc(); cyc();
    chk("t3_rec_busy", 32'(refresh_busy), 1);
    cyc();
    chk("t3_idle_again", 32'(refresh_busy), 0);
    chk("t3_ready_again", 32'(cpu_req_ready), 1);
    cyc();
    chk("t3_stays_idle", 32'(refresh_busy), 0);

    // Urgent refresh held in DRAIN by an in-flight CPU access
    refresh_tick = 1'b1; cyc(); refresh_tick = 1'b0;
    mem_busy = 1'b1;
    chk("t4_pend4", 32'(pending_cnt), 4);
    cyc();
    chk("t4_drain0", 32'(refresh_busy), 1);
    chk("t4_noreq0", 32'(ref_req), 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t4_drain_hold", 32'(ref_req), 0);
    end
    mem_busy = 1'b0;
    cyc();
    chk("t4_req_after", 32'(ref_req), 1);
    ref_ack = 1'b1; cyc(); ref_ack = 1'b0;
    chk("t4_fire_pend", 32'(pending_cnt), 3);
    cyc(); cyc(); cyc();
    chk("t4_idle", 32'(refresh_busy), 0);

    // Saturation and overflow flag
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t5_rst_pend", 32'(pending_cnt), 0);
    cpu_req_valid = 1'b0;
    refresh_tick = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    chk("t5_pend8", 32'(pending_cnt), 8);
    chk("t5_no_ovf", 32'(refresh_overflow), 0);
    cyc(); refresh_tick = 1'b0;
    chk("t5_sat8", 32'(pending_cnt), 8);
    chk("t5_ovf", 32'(refresh_overflow), 1);
    chk("t5_req_stuck", 32'(ref_req), 1);
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;
    chk("t5_ovf_clr", 32'(refresh_overflow), 0);
    refresh_tick = 1'b1; ref_ack = 1'b1; cyc();
    refresh_tick = 1'b0;
    chk("t5_tick_fire", 32'(pending_cnt), 8);
    chk("t5_tick_fire_ovf", 32'(refresh_overflow), 0);
    chk("t5_fire_done", 32'(ref_req), 0);
    cyc(); ref_ack = 1'b0;
    chk("t5_stray_ack", 32'(pending_cnt), 8);
    refresh_tick = 1'b1; ovf_clr = 1'b1; cyc();
    refresh_tick = 1'b0; ovf_clr = 1'b0;
    chk("t5_set_wins", 32'(refresh_overflow), 1);
    chk("t5_set_wins_pend", 32'(pending_cnt), 8);

    // Reset in the middle of a refresh request
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t6_rst_ovf", 32'(refresh_overflow), 0);
    refresh_tick = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    refresh_tick = 1'b0;
    chk("t6_pend5", 32'(pending_cnt), 5);
    chk("t6_in_req", 32'(ref_req), 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("t6_pend0", 32'(pending_cnt), 0);
    chk("t6_req0", 32'(ref_req), 0);
    chk("t6_idle", 32'(refresh_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
